// File: rtl/wb_writeback.sv
// Writeback stage: MEM/WB register, result select and
// register-file write-port arbitration against the MD unit.
module wb_writeback #(
  parameter int STARVE_LIMIT = 4,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_sel,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_load_data,
  input  logic [1:0]  mem_load_size,
  input  logic        mem_load_signed,
  input  logic [1:0]  mem_byte_off,
  input  logic [31:0] mem_pc,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        regwrite,
  output logic [4:0]  dst,
  output logic [31:0] Write_Data,
  output logic [31:0] instret
);

  logic        wb_valid;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_sel;
  logic [31:0] wb_alu;
  logic [31:0] wb_ld;
  logic [1:0]  wb_size;
  logic        wb_signed;
  logic [1:0]  wb_off;
  logic [31:0] wb_pc;

  logic [3:0]  starve_q;
  logic        force_bubble;
  logic        accept;
  logic        pipe_write;
  logic        md_write;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] result;

  assign force_bubble = (starve_q == 4'(STARVE_LIMIT));
  assign mem_ready    = !force_bubble;
  assign accept       = mem_valid & mem_ready;

  assign pipe_write = wb_valid & wb_regwrite &
                      !(R0_HARDWIRED && wb_rd == 5'd0);
  assign md_write   = md_valid &
                      !(R0_HARDWIRED && md_rd == 5'd0);

  // MEM/WB register: capture on handshake, bubble otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
      wb_sel      <= '0;
      wb_alu      <= '0;
      wb_ld       <= '0;
      wb_size     <= '0;
      wb_signed   <= 1'b0;
      wb_off      <= '0;
      wb_pc       <= '0;
    end else begin
      wb_valid <= accept;
      if (accept) begin
        wb_regwrite <= mem_regwrite;
        wb_rd       <= mem_rd;
        wb_sel      <= mem_sel;
        wb_alu      <= mem_alu_result;
        wb_ld       <= mem_load_data;
        wb_size     <= mem_load_size;
        wb_signed   <= mem_load_signed;
        wb_off      <= mem_byte_off;
        wb_pc       <= mem_pc;
      end
    end
  end

  // Little-endian lane pick and extension of load data
  always_comb begin
    ld_byte = wb_ld[7:0];
    unique case (wb_off)
      2'd0: ld_byte = wb_ld[7:0];
      2'd1: ld_byte = wb_ld[15:8];
      2'd2: ld_byte = wb_ld[23:16];
      2'd3: ld_byte = wb_ld[31:24];
    endcase
    ld_half = wb_off[1] ? wb_ld[31:16] : wb_ld[15:0];
    ld_ext  = wb_ld;
    unique case (wb_size)
      2'd0: ld_ext = {{24{wb_signed & ld_byte[7]}},
                      ld_byte};
      2'd1: ld_ext = {{16{wb_signed & ld_half[15]}},
                      ld_half};
      default: ld_ext = wb_ld;
    endcase
  end

  // Result select; reserved code falls back to ALU
  always_comb begin
    result = wb_alu;
    unique case (wb_sel)
      2'd1:    result = ld_ext;
      2'd2:    result = wb_pc + 32'd8;
      default: result = wb_alu;
    endcase
  end

  // Write-port arbitration, pipeline has priority
  always_comb begin
    regwrite   = 1'b0;
    dst        = '0;
    Write_Data = '0;
    md_ready   = 1'b0;
    unique case (1'b1)
      pipe_write: begin
        regwrite   = 1'b1;
        dst        = wb_rd;
        Write_Data = result;
      end
      default: begin
        md_ready = 1'b1;
        if (md_write) begin
          regwrite   = 1'b1;
          dst        = md_rd;
          Write_Data = md_data;
        end
      end
    endcase
  end

  // Denial counter; a full count forces one bubble then clears
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (force_bubble || !md_valid || md_ready) begin
      starve_q <= '0;
    end else if (pipe_write) begin
      starve_q <= starve_q + 4'd1;
    end
  end

  // Retired-instruction counter, bubbles excluded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret <= '0;
    end else if (wb_valid) begin
      instret <= instret + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_writeback.sv
// Bench for wb_writeback: behavioural model compared every
// cycle, plus directed vectors with literal expectations.
module tb_wb_writeback;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic        mem_regwrite = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [1:0]  mem_sel = '0;
  logic [31:0] mem_alu_result = '0;
  logic [31:0] mem_load_data = '0;
  logic [1:0]  mem_load_size = '0;
  logic        mem_load_signed = 1'b0;
  logic [1:0]  mem_byte_off = '0;
  logic [31:0] mem_pc = '0;
  logic        md_valid = 1'b0;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        md_ready;
  logic        regwrite;
  logic [4:0]  dst;
  logic [31:0] Write_Data;
  logic [31:0] instret;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  wb_writeback dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .mem_sel(mem_sel), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data),
    .mem_load_size(mem_load_size),
    .mem_load_signed(mem_load_signed),
    .mem_byte_off(mem_byte_off), .mem_pc(mem_pc),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data),
    .md_ready(md_ready), .regwrite(regwrite), .dst(dst),
    .Write_Data(Write_Data), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit          rw;
    bit [4:0]    rd;
    bit [1:0]    sel;
    bit [31:0]   alu;
    bit [31:0]   ld;
    bit [1:0]    sz;
    bit          sg;
    bit [1:0]    off;
    bit [31:0]   pc;
  } ins_t;

  ins_t        slot;
  int          starve = 0;
  bit [31:0]   retired = 0;

  function automatic bit [31:0] m_load(bit [31:0] w,
      bit [1:0] sz, bit sg, bit [1:0] off);
    int unsigned v;
    if (sz >= 2) return w;
    if (sz == 0) begin
      v = (w >> (8 * int'(off))) % 256;
      if (sg && v >= 128) return v - 256;
      return v;
    end
    v = (w >> (16 * (int'(off) / 2))) % 65536;
    if (sg && v >= 32768) return v - 65536;
    return v;
  endfunction

  function automatic bit [31:0] m_result(ins_t i);
    if (i.sel == 2) return i.pc + 32'd8;
    if (i.sel == 1) return m_load(i.ld, i.sz, i.sg, i.off);
    return i.alu;
  endfunction

  function automatic bit m_pipe();
    return slot.v && slot.rw && slot.rd != 0;
  endfunction

  // model state advance
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot    = '{default: 0};
      starve  = 0;
      retired = 0;
    end else begin
      bit grant;
      bit mrdy;
      grant = md_valid && !m_pipe();
      mrdy  = starve < LIM;
      if (starve == LIM || !md_valid || grant) starve = 0;
      else starve = starve + 1;
      if (slot.v) retired = retired + 1;
      if (mem_valid && mrdy)
        slot = '{1'b1, mem_regwrite, mem_rd, mem_sel,
                 mem_alu_result, mem_load_data, mem_load_size,
                 mem_load_signed, mem_byte_off, mem_pc};
      else
        slot = '{default: 0};
    end
  end

  task automatic cmp(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    #3;
    if (chk_en) begin
      bit        e_rw;
      bit [4:0]  e_dst;
      bit [31:0] e_wd;
      e_rw = 0; e_dst = 0; e_wd = 0;
      if (m_pipe()) begin
        e_rw = 1; e_dst = slot.rd; e_wd = m_result(slot);
      end else if (md_valid && md_rd != 0) begin
        e_rw = 1; e_dst = md_rd; e_wd = md_data;
      end
      cmp("m_regwrite", 32'(regwrite), 32'(e_rw));
      cmp("m_dst", 32'(dst), 32'(e_dst));
      cmp("m_wdata", Write_Data, e_wd);
      cmp("m_mem_ready", 32'(mem_ready), 32'(starve < LIM));
      cmp("m_md_ready", 32'(md_ready), 32'(!m_pipe()));
      cmp("m_instret", instret, retired);
    end
  end

  task automatic ins(bit rw, bit [4:0] rd, bit [1:0] sel,
      bit [31:0] alu, bit [31:0] ld, bit [1:0] sz, bit sg,
      bit [1:0] off, bit [31:0] pc);
    @(negedge clk);
    mem_valid = 1; mem_regwrite = rw; mem_rd = rd;
    mem_sel = sel; mem_alu_result = alu;
    mem_load_data = ld; mem_load_size = sz;
    mem_load_signed = sg; mem_byte_off = off; mem_pc = pc;
  endtask

  task automatic idle();
    @(negedge clk);
    mem_valid = 0; mem_regwrite = 0; mem_rd = 0;
  endtask

  localparam logic [31:0] LD = 32'h80FF7F01;

  initial begin
    idle();
    chk_en = 1;
    #2;
    cmp("rst_regwrite", 32'(regwrite), 32'd0);
    cmp("rst_dst", 32'(dst), 32'd0);
    cmp("rst_wdata", Write_Data, 32'd0);
    cmp("rst_mem_ready", 32'(mem_ready), 32'd1);
    cmp("rst_md_ready", 32'(md_ready), 32'd1);
    cmp("rst_instret", instret, 32'd0);
    idle();
    rst = 1;

    ins(1, 5, 0, 32'h1234, 0, 0, 0, 0, 0);
    idle(); #2;
    cmp("alu_regwrite", 32'(regwrite), 32'd1);
    cmp("alu_dst", 32'(dst), 32'd5);
    cmp("alu_wdata", Write_Data, 32'h1234);
    idle(); #2;
    cmp("alu_instret", instret, 32'd1);

    ins(1, 7, 1, 0, LD, 0, 1, 3, 0);
    ins(1, 7, 1, 0, LD, 1, 0, 2, 0); #2;
    cmp("ld_sb3", Write_Data, 32'hFFFFFF80);
    ins(1, 7, 1, 0, LD, 0, 1, 0, 0); #2;
    cmp("ld_uh2", Write_Data, 32'h000080FF);
    ins(1, 7, 1, 0, LD, 2, 0, 1, 0); #2;
    cmp("ld_sb0", Write_Data, 32'h00000001);
    ins(1, 31, 2, 0, 0, 0, 0, 0, 32'h00400010); #2;
    cmp("ld_word", Write_Data, 32'h80FF7F01);
    ins(1, 0, 0, 32'd77, 0, 0, 0, 0, 0); #2;
    cmp("link_wdata", Write_Data, 32'h00400018);
    cmp("link_dst", 32'(dst), 32'd31);
    ins(1, 6, 1, 0, LD, 1, 1, 3, 0); #2;
    cmp("r0_regwrite", 32'(regwrite), 32'd0);
    ins(1, 6, 3, 32'hCAFE, 0, 0, 0, 0, 0); #2;
    cmp("ld_sh3", Write_Data, 32'hFFFF80FF);
    idle(); #2;
    cmp("sel3_wdata", Write_Data, 32'hCAFE);
    idle(); #2;
    cmp("r0_instret", instret, 32'd9);

    md_valid = 1; md_rd = 9; md_data = 42; #2;
    cmp("md_idle_ready", 32'(md_ready), 32'd1);
    cmp("md_idle_regwrite", 32'(regwrite), 32'd1);
    cmp("md_idle_dst", 32'(dst), 32'd9);
    cmp("md_idle_wdata", Write_Data, 32'd42);
    idle();
    md_rd = 0; md_data = 5; #2;
    cmp("md_r0_ready", 32'(md_ready), 32'd1);
    cmp("md_r0_regwrite", 32'(regwrite), 32'd0);
    idle();
    md_valid = 0;

    ins(1, 3, 0, 32'd100, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      ins(1, 3, 0, 32'(100 + k), 0, 0, 0, 0, 0);
      md_valid = 1; md_rd = 10; md_data = 32'hABCD; #2;
      cmp($sformatf("stv_mem_ready_%0d", k),
          32'(mem_ready), 32'(k != 5));
      cmp($sformatf("stv_md_ready_%0d", k),
          32'(md_ready), 32'(k == 6));
      if (k == 6) begin
        cmp("stv_dst", 32'(dst), 32'd10);
        cmp("stv_wdata", Write_Data, 32'hABCD);
      end
    end
    ins(1, 4, 0, 32'd200, 0, 0, 0, 0, 0);
    md_valid = 0;
    ins(1, 4, 0, 32'd201, 0, 0, 0, 0, 0); #2;
    cmp("stv_resume", Write_Data, 32'd200);

    @(negedge clk);
    mem_valid = 0;
    #1 rst = 0;
    #1;
    cmp("arst_regwrite", 32'(regwrite), 32'd0);
    cmp("arst_instret", instret, 32'd0);
    cmp("arst_mem_ready", 32'(mem_ready), 32'd1);
    idle();
    idle();
    rst = 1;
    ins(1, 12, 0, 32'h55, 0, 0, 0, 0, 0);
    idle(); #2;
    cmp("post_rst_wdata", Write_Data, 32'h55);
    idle(); #2;
    cmp("post_rst_instret", instret, 32'd1);
    idle();
    idle();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
